// File: rtl/atm_session_driver.sv
// Customer-side session sequencer for the ATM core: takes one request at a time
// over valid/ready, walks the ATM through card/language/PIN/op/amount and reports a status.
module atm_session_driver #(
    parameter int PIN_WIDTH = 4,
    parameter int AMT_WIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_opcode,
    input  logic [AMT_WIDTH-1:0] req_amount,
    input  logic [PIN_WIDTH-1:0] req_pin,
    input  logic                 req_language,
    input  logic                 req_more,
    output logic                 cardIn,
    output logic                 Language,
    output logic                 Another_Operation,
    output logic                 moneyDeposited,
    output logic                 ejectCard,
    output logic [PIN_WIDTH-1:0] password,
    output logic [1:0]           opCode,
    output logic [AMT_WIDTH-1:0] inputAmount,
    input  logic                 correctPassword,
    input  logic                 Balance_Shown,
    input  logic                 Deposited_Successfully,
    input  logic                 Withdrawed_Successfully,
    input  logic                 ATM_Usage_Finished,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_status,
    output logic [7:0]           txn_count,
    output logic                 busy
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE = 4'd0, CARD = 4'd1, LANG = 4'd2, PIN = 4'd3, OP = 4'd4,
        AMOUNT = 4'd5, WAIT_DONE = 4'd6, RESP = 4'd7, NEXT = 4'd8, EJECT = 4'd9
    } state_t;

    state_t                 state_r, state_s;
    logic [CW-1:0]          win_r;
    logic                   accept_s, expired_s, done_match_s;
    logic [1:0]             status_s;
    logic [1:0]             op_r, lat_op_s;
    logic [AMT_WIDTH-1:0]   amt_r, lat_amt_s;
    logic [PIN_WIDTH-1:0]   pin_r, lat_pin_s;
    logic                   lang_r, lat_lang_s, more_r, lat_more_s;
    logic                   card_s, lang_s, another_s, money_s, eject_s, rvalid_s, ready_s, busy_s;
    logic [PIN_WIDTH-1:0]   pass_s;
    logic [1:0]             opc_s, rstatus_s;
    logic [AMT_WIDTH-1:0]   amt_s;
    logic [7:0]             count_s;

    assign accept_s  = req_valid & req_ready;
    assign expired_s = (win_r == CW'(TIMEOUT - 1));

    // Completion flag that belongs to the latched opcode; other flags are ignored.
    always_comb begin
        done_match_s = 1'b0;
        case (op_r)
            2'b01:   done_match_s = Balance_Shown;
            2'b10:   done_match_s = Deposited_Successfully;
            2'b11:   done_match_s = Withdrawed_Successfully;
            default: done_match_s = 1'b0;
        endcase
    end

    // State register, request latches and wait-window counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            win_r   <= {CW{1'b0}};
            op_r    <= 2'b00;
            amt_r   <= {AMT_WIDTH{1'b0}};
            pin_r   <= {PIN_WIDTH{1'b0}};
            lang_r  <= 1'b0;
            more_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            win_r   <= ((state_s != state_r) || (state_r == IDLE)) ? {CW{1'b0}} : win_r + CW'(1);
            op_r    <= lat_op_s;
            amt_r   <= lat_amt_s;
            pin_r   <= lat_pin_s;
            lang_r  <= lat_lang_s;
            more_r  <= lat_more_s;
        end
    end

    // Next-state logic; status_s is the status carried into RESP.
    always_comb begin
        state_s  = state_r;
        status_s = 2'b00;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (req_opcode == 2'b00) begin
                        state_s  = RESP;
                        status_s = 2'b11;
                    end else begin
                        state_s = CARD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CARD:   state_s = LANG;
            LANG:   state_s = PIN;
            PIN: begin
                if (correctPassword) begin
                    state_s = OP;
                end else if (expired_s) begin
                    state_s  = RESP;
                    status_s = 2'b01;
                end else begin
                    state_s = PIN;
                end
            end
            OP:     state_s = AMOUNT;
            AMOUNT: state_s = WAIT_DONE;
            WAIT_DONE: begin
                if (done_match_s) begin
                    state_s = RESP;
                end else if (expired_s) begin
                    state_s  = RESP;
                    status_s = 2'b10;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            RESP:   state_s = ((rsp_status == 2'b00) && more_r) ? NEXT : EJECT;
            NEXT: begin
                if (accept_s) begin
                    if (req_opcode == 2'b00) begin
                        state_s  = RESP;
                        status_s = 2'b11;
                    end else begin
                        state_s = OP;
                    end
                end else if (expired_s) begin
                    state_s = EJECT;
                end else begin
                    state_s = NEXT;
                end
            end
            EJECT: begin
                if (ATM_Usage_Finished || expired_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = EJECT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Next values of latches and outputs, keyed on the state being entered.
    always_comb begin
        if (accept_s) begin
            lat_op_s   = req_opcode;
            lat_amt_s  = req_amount;
            lat_more_s = req_more;
        end else begin
            lat_op_s   = op_r;
            lat_amt_s  = amt_r;
            lat_more_s = more_r;
        end
        if (accept_s && (state_r == IDLE)) begin
            lat_pin_s  = req_pin;
            lat_lang_s = req_language;
        end else begin
            lat_pin_s  = pin_r;
            lat_lang_s = lang_r;
        end
        card_s    = cardIn;
        lang_s    = Language;
        pass_s    = password;
        opc_s     = 2'b00;
        amt_s     = inputAmount;
        money_s   = 1'b0;
        another_s = Another_Operation;
        case (state_s)
            IDLE: begin
                card_s    = 1'b0;
                lang_s    = 1'b0;
                pass_s    = {PIN_WIDTH{1'b0}};
                amt_s     = {AMT_WIDTH{1'b0}};
                another_s = 1'b0;
            end
            CARD:   card_s = 1'b1;
            LANG:   lang_s = lat_lang_s;
            PIN:    pass_s = lat_pin_s;
            OP:     opc_s  = lat_op_s;
            AMOUNT: begin
                opc_s   = opCode;
                amt_s   = (lat_op_s == 2'b01) ? {AMT_WIDTH{1'b0}} : lat_amt_s;
                money_s = (lat_op_s == 2'b10);
            end
            WAIT_DONE: begin
                opc_s   = opCode;
                money_s = moneyDeposited;
            end
            RESP:   opc_s = opCode;
            NEXT: begin
                amt_s     = {AMT_WIDTH{1'b0}};
                another_s = 1'b1;
            end
            EJECT:  another_s = 1'b0;
            default: begin
                card_s    = 1'b0;
                another_s = 1'b0;
            end
        endcase
        eject_s   = (state_s == EJECT);
        rvalid_s  = (state_s == RESP);
        rstatus_s = rvalid_s ? status_s : rsp_status;
        ready_s   = (state_s == IDLE) || (state_s == NEXT);
        busy_s    = (state_s != IDLE);
        count_s   = (rvalid_s && (status_s == 2'b00) && (txn_count != 8'hFF)) ? txn_count + 8'd1 : txn_count;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready         <= 1'b1;
            cardIn            <= 1'b0;
            Language          <= 1'b0;
            Another_Operation <= 1'b0;
            moneyDeposited    <= 1'b0;
            ejectCard         <= 1'b0;
            password          <= {PIN_WIDTH{1'b0}};
            opCode            <= 2'b00;
            inputAmount       <= {AMT_WIDTH{1'b0}};
            rsp_valid         <= 1'b0;
            rsp_status        <= 2'b00;
            txn_count         <= 8'd0;
            busy              <= 1'b0;
        end else begin
            req_ready         <= ready_s;
            cardIn            <= card_s;
            Language          <= lang_s;
            Another_Operation <= another_s;
            moneyDeposited    <= money_s;
            ejectCard         <= eject_s;
            password          <= pass_s;
            opCode            <= opc_s;
            inputAmount       <= amt_s;
            rsp_valid         <= rvalid_s;
            rsp_status        <= rstatus_s;
            txn_count         <= count_s;
            busy              <= busy_s;
        end
    end
endmodule

// File: tb/tb_atm_session_driver.sv
// Directed bench for atm_session_driver: table of single-op sessions plus
// hand-written multi-op, NEXT-expiry and mid-session reset sequences.
module tb_atm_session_driver;
    localparam int PW = 4;
    localparam int AW = 32;
    localparam int TO = 16;
    localparam logic [63:0] IDLE_EXP = 64'h0000_0040_0000_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0, req_ready;
    logic [1:0]    req_opcode = 2'b00;
    logic [AW-1:0] req_amount = 32'd0;
    logic [PW-1:0] req_pin = 4'd0;
    logic          req_language = 1'b0, req_more = 1'b0;
    logic          cardIn, Language, Another_Operation, moneyDeposited, ejectCard;
    logic [PW-1:0] password;
    logic [1:0]    opCode;
    logic [AW-1:0] inputAmount;
    logic          correctPassword = 1'b0, Balance_Shown = 1'b0, Deposited_Successfully = 1'b0;
    logic          Withdrawed_Successfully = 1'b0, ATM_Usage_Finished = 1'b0;
    logic          rsp_valid;
    logic [1:0]    rsp_status;
    logic [7:0]    txn_count;
    logic          busy;

    int n_total = 0;
    int n_bad   = 0;

    atm_session_driver #(.PIN_WIDTH(PW), .AMT_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_amount(req_amount), .req_pin(req_pin), .req_language(req_language), .req_more(req_more),
        .cardIn(cardIn), .Language(Language), .Another_Operation(Another_Operation),
        .moneyDeposited(moneyDeposited), .ejectCard(ejectCard), .password(password),
        .opCode(opCode), .inputAmount(inputAmount), .correctPassword(correctPassword),
        .Balance_Shown(Balance_Shown), .Deposited_Successfully(Deposited_Successfully),
        .Withdrawed_Successfully(Withdrawed_Successfully), .ATM_Usage_Finished(ATM_Usage_Finished),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .txn_count(txn_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pin;
        logic        lang;
        logic [1:0]  op;
        logic [31:0] amt;
        int          pw_lat;     // cycles before correctPassword pulse (>= TO: never)
        int          dn_lat;     // cycles into WAIT_DONE before the flag pulse
        logic [2:0]  dn_flag;    // {Balance_Shown, Deposited, Withdrawed}
        logic [1:0]  exp_status;
        logic [7:0]  exp_count;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({opCode, password, busy, req_ready, cardIn, Language, Another_Operation,
                    moneyDeposited, ejectCard, rsp_valid, inputAmount});
    endfunction

    task automatic send_req(input logic [1:0] op, input logic [31:0] amt, input logic [3:0] pin,
                            input logic lang, input logic more);
        req_opcode = op; req_amount = amt; req_pin = pin; req_language = lang; req_more = more;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic eject_finish(input int lat, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            ATM_Usage_Finished = (k == lat);
            tick();
            ATM_Usage_Finished = 1'b0;
        end
        chk("idle_after_eject", outs(), IDLE_EXP);
    endtask

    task automatic run_vec(input vec_t v);
        int ncyc;
        send_req(v.op, v.amt, v.pin, v.lang, 1'b0);
        if (v.op == 2'b00) begin
            chk("abort_rsp", 64'({rsp_valid, rsp_status, cardIn, txn_count}),
                64'({1'b1, 2'b11, 1'b0, v.exp_count}));
        end else begin
            chk("card", 64'({cardIn, req_ready, busy}), 64'({1'b1, 1'b0, 1'b1}));
            tick();
            chk("lang", 64'(Language), 64'(v.lang));
            tick();
            chk("pin", 64'({password, opCode}), 64'({v.pin, 2'b00}));
            ncyc = (v.exp_status == 2'b01) ? TO : v.pw_lat + 1;
            for (int k = 0; k < ncyc; k++) begin
                correctPassword = (k == v.pw_lat);
                tick();
                correctPassword = 1'b0;
                if (k < ncyc - 1) chk("pin_wait", 64'({rsp_valid, opCode}), 64'd0);
            end
            if (v.exp_status == 2'b01) begin
                chk("badpin_rsp", 64'({rsp_valid, rsp_status, opCode, txn_count}),
                    64'({1'b1, 2'b01, 2'b00, v.exp_count}));
            end else begin
                chk("op", 64'(opCode), 64'(v.op));
                tick();
                chk("amount", 64'({moneyDeposited, inputAmount}),
                    64'({v.op == 2'b10, (v.op == 2'b01) ? 32'd0 : v.amt}));
                tick();
                chk("wait_money", 64'(moneyDeposited), 64'(v.op == 2'b10));
                ncyc = (v.exp_status == 2'b10) ? TO : v.dn_lat + 1;
                for (int k = 0; k < ncyc; k++) begin
                    {Balance_Shown, Deposited_Successfully, Withdrawed_Successfully} =
                        (k == v.dn_lat) ? v.dn_flag : 3'b000;
                    tick();
                    {Balance_Shown, Deposited_Successfully, Withdrawed_Successfully} = 3'b000;
                    if (k < ncyc - 1) chk("done_wait", 64'(rsp_valid), 64'd0);
                end
                chk("done_rsp", 64'({rsp_valid, rsp_status, txn_count, opCode, moneyDeposited}),
                    64'({1'b1, v.exp_status, v.exp_count, v.op, 1'b0}));
            end
        end
        tick();
        chk("eject", 64'({ejectCard, rsp_valid, Another_Operation, cardIn}),
            64'({1'b1, 1'b0, 1'b0, v.op != 2'b00}));
        eject_finish(1, 2);
    endtask

    initial begin
        vec_t v;
        //         pin    lang  op     amt          pw  dn  flag    status  count
        vecs[0] = '{4'h5, 1'b0, 2'b11, 32'h0000_0040, 99, 0, 3'b001, 2'b01, 8'd0};  // bad PIN
        vecs[1] = '{4'hA, 1'b1, 2'b11, 32'h0000_0040, 2,  3, 3'b001, 2'b00, 8'd1};  // withdraw
        vecs[2] = '{4'h7, 1'b0, 2'b11, 32'h0000_0010, 0,  4, 3'b010, 2'b10, 8'd1};  // wrong flag
        vecs[3] = '{4'h3, 1'b1, 2'b01, 32'h0000_1234, 0,  0, 3'b100, 2'b00, 8'd2};  // balance, flags on entry
        vecs[4] = '{4'h9, 1'b0, 2'b10, 32'h0000_0099, 15, 15, 3'b010, 2'b00, 8'd3}; // final-cycle flags
        vecs[5] = '{4'h1, 1'b0, 2'b00, 32'h0000_0000, 0,  0, 3'b000, 2'b11, 8'd3};  // abort
        vecs[6] = '{4'hC, 1'b1, 2'b11, 32'h0000_0020, 1,  2, 3'b100, 2'b10, 8'd3};  // balance flag on withdraw

        repeat (3) tick();
        chk("reset_outs", outs(), IDLE_EXP);
        chk("reset_status_cnt", 64'({rsp_status, txn_count}), 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_hold", outs(), IDLE_EXP);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Multi-op: balance with more=1, then deposit accepted in NEXT.
        send_req(2'b01, 32'd0, 4'h6, 1'b0, 1'b1);
        tick(); tick();
        correctPassword = 1'b1; tick(); correctPassword = 1'b0;
        chk("mo_op1", 64'(opCode), 64'd1);
        tick();
        chk("mo_amt1", 64'({moneyDeposited, inputAmount}), 64'd0);
        tick();
        Balance_Shown = 1'b1; tick(); Balance_Shown = 1'b0;
        chk("mo_rsp1", 64'({rsp_valid, rsp_status, txn_count}), 64'({1'b1, 2'b00, 8'd4}));
        tick();
        chk("mo_next", 64'({Another_Operation, req_ready, busy, cardIn, rsp_valid, opCode, inputAmount}),
            64'({1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 32'd0}));
        send_req(2'b10, 32'h0000_0040, 4'hF, 1'b1, 1'b0);
        chk("mo_op2", 64'({opCode, password, Language, req_ready, Another_Operation}),
            64'({2'b10, 4'h6, 1'b0, 1'b0, 1'b1}));
        tick();
        chk("mo_amt2", 64'({moneyDeposited, inputAmount}), 64'({1'b1, 32'h0000_0040}));
        tick();
        Deposited_Successfully = 1'b1; tick(); Deposited_Successfully = 1'b0;
        chk("mo_rsp2", 64'({rsp_valid, rsp_status, txn_count, moneyDeposited}),
            64'({1'b1, 2'b00, 8'd5, 1'b0}));
        tick();
        chk("mo_eject", 64'({ejectCard, Another_Operation}), 64'({1'b1, 1'b0}));
        eject_finish(0, 1);

        // NEXT expiry: more=1, no follow-on request; EJECT then expires too.
        send_req(2'b01, 32'd0, 4'h2, 1'b0, 1'b1);
        tick(); tick();
        correctPassword = 1'b1; tick(); correctPassword = 1'b0;
        tick(); tick();
        Balance_Shown = 1'b1; tick(); Balance_Shown = 1'b0;
        chk("nx_rsp", 64'({rsp_valid, rsp_status, txn_count}), 64'({1'b1, 2'b00, 8'd6}));
        tick();
        for (int k = 0; k < TO; k++) begin
            tick();
            if (k < TO - 1) chk("nx_wait", 64'({rsp_valid, Another_Operation, ejectCard}), 64'({1'b0, 1'b1, 1'b0}));
        end
        chk("nx_eject", 64'({ejectCard, rsp_valid, Another_Operation}), 64'({1'b1, 1'b0, 1'b0}));
        eject_finish(99, TO);

        // Reset in WAIT_DONE, then a clean withdraw.
        send_req(2'b11, 32'h0000_0040, 4'hA, 1'b1, 1'b0);
        tick(); tick();
        correctPassword = 1'b1; tick(); correctPassword = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_outs", outs(), IDLE_EXP);
        chk("rst_mid_cnt", 64'({rsp_status, txn_count}), 64'd0);
        reset = 1'b0;
        tick();
        v = vecs[1];
        v.exp_count = 8'd1;
        run_vec(v);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/atm_session_driver.md
# atm_session_driver

Customer-side session sequencer that drives the ATM controller's card, language, PIN, opcode and amount inputs and consumes its completion flags. It accepts one transaction request at a time over a valid/ready handshake and walks the ATM through a full session. It reports one status word per request and keeps multi-operation sessions open via `Another_Operation`. It sits between the host/keypad front end and the ATM core, as the initiator of the ATM's input protocol.

## Interface
- `PIN_WIDTH`, 4: PIN width.
- `AMT_WIDTH`, 32: amount width.
- `TIMEOUT`, 16: response window in cycles for every wait state; must be ≥2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high; clears all state and outputs.
- `req_valid` in 1 / `req_ready` out 1: request handshake; transfer when both are high at a rising edge.
- `req_opcode` in 2: 00 end session, 01 balance, 10 deposit, 11 withdraw.
- `req_amount` in AMT_WIDTH, `req_pin` in PIN_WIDTH, `req_language` in 1, `req_more` in 1 (another op follows).
- `cardIn`, `Language`, `Another_Operation`, `moneyDeposited`, `ejectCard` out 1: ATM drive signals.
- `password` out PIN_WIDTH, `opCode` out 2, `inputAmount` out AMT_WIDTH: ATM drive buses.
- `correctPassword`, `Balance_Shown`, `Deposited_Successfully`, `Withdrawed_Successfully`, `ATM_Usage_Finished` in 1: ATM status.
- `rsp_valid` out 1: one-cycle pulse. `rsp_status` out 2: 00 OK, 01 bad PIN, 10 timeout, 11 aborted.
- `txn_count` out 8: OK responses since reset, saturating at 255.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- All outputs are registered. Reset value of every output is 0, except `req_ready`, which is 1 (IDLE).
- States: IDLE, CARD, LANG, PIN, OP, AMOUNT, WAIT_DONE, RESP, NEXT, EJECT.
- IDLE: `req_ready`=1. On transfer, latch the request fields and go to CARD.
  - If the latched opcode is 00, go to RESP with status 11 instead, then to EJECT.
- CARD (1 cycle): `cardIn`=1, held until EJECT exits.
- LANG (1 cycle): `Language`=latched language, held until the session ends.
- PIN: `password`=latched PIN, held until the session ends. Wait for `correctPassword`.
  - On seeing it, go to OP.
  - On window expiry, go to RESP with status 01; `opCode` stays 00.
- OP (1 cycle): `opCode`=latched opcode, held through RESP.
- AMOUNT (1 cycle): `inputAmount`=latched amount. `moneyDeposited`=1 for opcode 10 only, held through WAIT_DONE.
  - For opcode 01, `inputAmount` is driven as 0.
- WAIT_DONE: wait for the flag matching the opcode: 01→`Balance_Shown`, 10→`Deposited_Successfully`, 11→`Withdrawed_Successfully`.
  - Non-matching flags are ignored.
  - Match → RESP with status 00. Expiry → RESP with status 10.
- RESP (1 cycle): `rsp_valid`=1. Increment `txn_count` if status is 00 and the count is below 255.
  - If status is 00 and `req_more` was latched, go to NEXT; otherwise go to EJECT.
- NEXT: `Another_Operation`=1, `req_ready`=1, `opCode` and `inputAmount` cleared.
  - On transfer, latch only opcode, amount and more (PIN and language ignored). Go to OP, or to RESP with status 11 if the opcode is 00.
  - On window expiry, go to EJECT with no response.
- EJECT: `ejectCard`=1 and `Another_Operation`=0. Wait for `ATM_Usage_Finished`.
  - On the flag or on expiry, go to IDLE and clear all ATM-facing outputs.
- Window counter: cleared on entry to each wait state (PIN, WAIT_DONE, NEXT, EJECT).
  - A flag sampled in any of the first TIMEOUT cycles in the state counts.
  - Expiry is taken at the end of cycle TIMEOUT. Width is clog2(TIMEOUT+1).
- Simultaneous events:
  - A matching flag in the final window cycle counts as success.
  - A flag high on the entry cycle counts.
  - `req_valid` outside IDLE/NEXT is ignored (`req_ready`=0).
- Reset mid-session: the next edge forces IDLE, all outputs to reset values and `txn_count`=0. No response is emitted.

## Timing
- Request accepted at edge N: CARD at N+1, LANG at N+2, PIN window starts at N+3.
- Best case with flags present on entry:
  - OP at N+4, AMOUNT at N+5, WAIT_DONE at N+6, `rsp_valid` at N+7.
- Each state transition costs exactly one cycle. Output changes appear at the edge that enters the state.
- Follow-on request accepted in NEXT at edge M: OP at M+1, `rsp_valid` no earlier than M+4.
- Throughput: one request in flight; `req_ready` is low from acceptance until NEXT or IDLE.

## Test plan
- Withdraw: pin 1010, opcode 11, amount 0x40, more=0. The ATM model raises `correctPassword` 2 cycles into PIN and `Withdrawed_Successfully` 3 cycles into WAIT_DONE.
  - Required: `rsp_status`=00, `txn_count`=1, `ejectCard` high, IDLE after `ATM_Usage_Finished`.
- Bad PIN: `correctPassword` never asserted.
  - Required: `rsp_valid` with 01 exactly 16 cycles after PIN entry, `opCode` never leaves 00, `txn_count` stays 0.
- Multi-op: balance (01, more=1), then deposit 0x40 (10, more=0).
  - Required: `Another_Operation`=1 in NEXT, second op skips CARD/LANG/PIN, `moneyDeposited` high only for the deposit, two OK responses, `txn_count`=2.
- Wrong flag: withdraw with only `Deposited_Successfully` pulsed.
  - Required: timeout status 10 after 16 cycles in WAIT_DONE.
- NEXT expiry: more=1 with no follow-on request for 16 cycles.
  - Required: EJECT entered, no extra `rsp_valid`.
- Reset mid-WAIT_DONE.
  - Required: all outputs 0 and `req_ready`=1 on the next edge; a subsequent withdraw completes with OK.
